// File: rtl/debounce_fsm_if.sv
// Signal bundle between a raw pushbutton source and debounce_fsm.
// The master drives the tick strobe and raw input; the slave returns the debounced level.
interface debounce_fsm_if;
    logic tick;
    logic db_in;
    logic db_out;

    modport master (
        output tick,
        output db_in,
        input  db_out
    );

    modport slave (
        input  tick,
        input  db_in,
        output db_out
    );
endinterface

// File: rtl/debounce_fsm.sv
// Tick-paced debouncer: db_out follows db_in only after STABLE_TICKS consecutive stable ticks.
// Define DEBOUNCE_SYNC_EN to pass db_in through a two-flop synchronizer (adds 2 clk of latency).
module debounce_fsm #(
    parameter int unsigned STABLE_TICKS = 3,
    parameter int unsigned CNT_W        = $clog2(STABLE_TICKS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    debounce_fsm_if.slave  bus
);

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b11,
        WAIT0 = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             out_q;
    logic             din;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.db_in};
        end
    end

    assign din = sync_q[1];
`else
    assign din = bus.db_in;
`endif

    // A level reversal in a WAIT state takes priority over a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ZERO;
            cnt   <= '0;
            out_q <= 1'b0;
        end else begin
            case (state)
                ZERO: begin
                    out_q <= 1'b0;
                    if (din) begin
                        state <= WAIT1;
                        cnt   <= '0;
                    end
                end
                WAIT1: begin
                    out_q <= 1'b0;
                    if (!din) begin
                        state <= ZERO;
                        cnt   <= '0;
                    end else if (bus.tick) begin
                        if (cnt == LAST) begin
                            state <= ONE;
                            cnt   <= '0;
                            out_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ONE: begin
                    out_q <= 1'b1;
                    if (!din) begin
                        state <= WAIT0;
                        cnt   <= '0;
                    end
                end
                WAIT0: begin
                    out_q <= 1'b1;
                    if (din) begin
                        state <= ONE;
                        cnt   <= '0;
                    end else if (bus.tick) begin
                        if (cnt == LAST) begin
                            state <= ZERO;
                            cnt   <= '0;
                            out_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ZERO;
                    cnt   <= '0;
                    out_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.db_out = out_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Scoreboard bench for debounce_fsm: stimulus queues expected db_out per clock edge,
// a negedge monitor pops and compares against both instances (STABLE_TICKS=3 and =1).
module tb_debounce_fsm;

`ifdef DEBOUNCE_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic ph = 1'b0;
    string tname = "init";

    typedef struct {
        int    cyc;
        int    id;
        logic  val;
        string name;
    } exp_t;

    exp_t q[$];

    debounce_fsm_if bus0 ();
    debounce_fsm_if bus1 ();

    debounce_fsm #(.STABLE_TICKS(3)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    debounce_fsm #(.STABLE_TICKS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_now(input string n, input logic act, input logic req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: db_out=%b expected %b", n, act, req);
        end
    endtask

    task automatic push_exp(input int c, input int id, input logic v);
        exp_t e;
        e.cyc  = c;
        e.id   = id;
        e.val  = v;
        e.name = tname;
        q.push_back(e);
    endtask

    // Drive one edge's inputs and queue the expected db_out after that edge.
    task automatic step(input logic d0, input logic e0, input logic d1, input logic e1);
        bus0.db_in = d0;
        bus0.tick  = ph;
        ph         = ~ph;
        bus1.db_in = d1;
        bus1.tick  = 1'b1;
        push_exp(cyc + 1, 0, e0);
        push_exp(cyc + 1, 1, e1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_total++;
            act = (e.id == 0) ? bus0.db_out : bus1.db_out;
            if (e.cyc != cyc) begin
                $display("FAIL %s dut%0d: check for edge %0d missed at edge %0d", e.name, e.id, e.cyc, cyc);
            end else if (act !== e.val) begin
                $display("FAIL %s dut%0d edge %0d: db_out=%b expected %b", e.name, e.id, cyc, act, e.val);
            end else begin
                n_pass++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus0.db_in = 1'b0;
        bus0.tick  = 1'b0;
        bus1.db_in = 1'b0;
        bus1.tick  = 1'b1;

        #3;
        check_now("reset_init dut0", bus0.db_out, 1'b0);
        check_now("reset_init dut1", bus1.db_out, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Short bounce: one counted tick, then release; output must never move.
        tname = "bounce";
        ph = 1'b1;
        for (int i = 0; i < 13; i++) step(i < 3, 1'b0, 1'b0, 1'b0);

        // Clean press: rises on the 3rd tick-high edge after WAIT1 entry.
        tname = "press";
        ph = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, i >= 6 + SD, 1'b0, 1'b0);

        // Release with a one-cycle return to 1 that restarts the WAIT0 count.
        tname = "release";
        ph = 1'b1;
        for (int i = 0; i < 16; i++) step(i == 3, i < 10 + SD, 1'b0, 1'b0);

        // Reach cnt=2 in WAIT1, then reset; re-press needs the full count.
        tname = "midwait";
        ph = 1'b1;
        for (int i = 0; i <= 4 + SD; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_now("midwait_rst", bus0.db_out, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tname = "repress";
        ph = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, i >= 6 + SD, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle while db_out=1 and db_in held high.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_now("async_rst dut0", bus0.db_out, 1'b0);
        @(negedge clk);
        check_now("rst_hold dut0", bus0.db_out, 1'b0);
        rst = 1'b0;
        tname = "post_rst";
        ph = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, i >= 6 + SD, 1'b0, 1'b0);

        // STABLE_TICKS=1 with tick constantly high.
        tname = "st1";
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, i >= 1 + SD);

        repeat (2) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_total++;
            $display("FAIL %s dut%0d: expectation for edge %0d never checked", e.name, e.id, e.cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
